demux_1t2_buf: RTL and testbench
================================

# demux_1t2_buf

Registered 1-to-2 stream demultiplexer: the steering counterpart to the datapath's 2:1 muxes. It accepts one `n`-bit valid/ready stream plus a per-beat `SEL` and delivers each beat to output lane 0 or lane 1. Each lane has its own 2-entry buffer, so a stalled consumer never blocks the other lane. It sits between a single producer (e.g. a result/writeback source) and two independent consumers.

## Interface
- `n`, 32, data width of every beat.
- `CLK`  in  1  rising-edge clock for all state.
- `RST_N`  in  1  reset, asynchronous and active-low. All state is cleared while it is low.
- `IN_VALID`  in  1  producer has a beat on `D_IN` / `SEL`.
- `IN_READY`  out  1  the beat is accepted this cycle when `IN_VALID & IN_READY`.
- `SEL`  in  1  destination lane of the current beat (0 → lane 0, 1 → lane 1).
- `D_IN`  in  n  beat data.
- `OUT0_VALID`, `OUT1_VALID`  out  1  lane k holds a beat on `D_OUTk`.
- `OUT0_READY`, `OUT1_READY`  in  1  consumer k takes the beat when `OUTk_VALID & OUTk_READY`.
- `D_OUT0`, `D_OUT1`  out  n  head-of-lane data.

## Operation
- Each lane is a 2-entry FIFO with:
  - occupancy `cnt` ∈ {0,1,2}
  - 1-bit write pointer and 1-bit read pointer (wrap 1→0)
  - per-lane states: EMPTY (cnt=0), HALF (cnt=1), FULL (cnt=2)
- `IN_READY = RST_N & (cnt[SEL] != 2)`. This is combinational from `SEL` and the lane-`SEL` occupancy only. It never depends on `OUTk_READY`.
- Push: `IN_VALID & IN_READY` writes `D_IN` into lane `SEL` at its write pointer. The write pointer advances and `cnt` increments.
- Pop: `OUTk_VALID & OUTk_READY` advances lane k's read pointer and decrements `cnt`.
- Push and pop on the same lane in the same cycle:
  - `cnt` is unchanged and both pointers advance.
  - Allowed only from HALF. EMPTY has nothing to pop; FULL refuses the push.
- FULL lane with a pop in the same cycle: the push is still refused that cycle (no ready-through path). It is accepted the next cycle.
- A push to one lane while the other lane pops: the two operations are independent.
- `OUTk_VALID = (cnt[k] != 0)`. `D_OUTk` = entry at lane k's read pointer, taken from registers (no bypass from `D_IN`).
- A stalled lane holds `D_OUTk` and `OUTk_VALID` stable until the beat is taken.
- Beats leave each lane in the order they were accepted. There is no ordering relationship between lanes.
- `SEL` and `D_IN` are don't-care when `IN_VALID` = 0. An `X` on `SEL` while `IN_VALID` = 0 must not corrupt state.

## Timing
- Latency: a beat accepted at edge t appears with `OUTk_VALID`=1 after edge t (visible in cycle t+1). Minimum 1 cycle, no zero-cycle path.
- Throughput: 1 beat/cycle per lane when its consumer holds READY=1. An alternating `SEL` pattern sustains 1 beat/cycle total.
- Reset, while `RST_N` is low and immediately after release:
  - `IN_READY`=0 while low
  - `OUT0_VALID`=`OUT1_VALID`=0, `D_OUT0`=`D_OUT1`=0
  - `cnt`=0, pointers=0, storage=0
- Reset asserted mid-operation: all buffered beats are dropped. There is no partial transfer, and the first accept after release lands in entry 0.
- All outputs except `IN_READY` are direct register outputs.

## Structure
- Package `demux_pkg`:
  - `localparam LANE_DEPTH = 2`
  - `typedef logic [1:0] occ_t`
  - `typedef enum logic [1:0] {EMPTY, HALF, FULL} lane_state_t`
- Sub-module `lane_fifo2 #(n)`:
  - one 2-entry lane (push/pop, `cnt`, pointers, async active-low reset)
  - instantiated twice
  - the top contains only the `SEL` steering of push enable and the `IN_READY` select.

## Test plan
- Reset release, then `IN_VALID`=1, `SEL`=0, `D_IN`=0xA5A5_0001 → the next cycle `OUT0_VALID`=1, `D_OUT0`=0xA5A5_0001, `OUT1_VALID`=0.
- `OUT1_READY`=0. Push 0x11, 0x22 to lane 1 → `IN_READY`=0 while `SEL`=1, but `IN_READY`=1 with `SEL`=0. Lane 0 accepts 0x33, which appears on `D_OUT0` the next cycle.
- Lane 1 FULL. Assert `OUT1_READY`=1 and push (`SEL`=1, 0x44) in the same cycle → the push is refused. Next cycle: `D_OUT1`=0x22, the push is accepted, and lane 1 then drains 0x22, 0x44 in order.
- Both READY=1. Stream 8 beats with alternating `SEL` and data 0..7 → lane 0 outputs 0,2,4,6 and lane 1 outputs 1,3,5,7, with `IN_READY` held at 1 throughout.
- Lane 0 HALF with 0x55. Push 0x66 and pop in the same cycle → `cnt`=1 and `D_OUT0`=0x66 the next cycle.
- Two beats buffered per lane, then drop `RST_N` mid-cycle (asynchronously) → all VALIDs and `IN_READY` are 0 immediately. After release, push 0x77 to lane 1 → `D_OUT1`=0x77 one cycle later, with no stale beats.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared types for the 1-to-2 buffered stream demultiplexer.
// A lane's state encoding equals its occupancy, so the two convert by a plain cast.
package demux_pkg;
    localparam int LANE_DEPTH = 2;

    typedef logic [1:0] occ_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } lane_state_t;
endpackage

// File: rtl/lane_fifo2.sv
// One 2-entry output lane: registered head data and valid, async active-low reset.
// o_state exposes the lane FSM (EMPTY/HALF/FULL) for steering and debug.
module lane_fifo2
    import demux_pkg::*;
#(
    parameter int n = 32
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_push,
    input  logic [n-1:0] i_data,
    input  logic         i_ready,
    output logic         o_valid,
    output logic [n-1:0] o_data,
    output lane_state_t  o_state
);
    // Handshake: a beat leaves when o_valid & i_ready; i_push is only honoured
    // when the lane is not FULL, so a same-cycle pop never frees a slot early.

    logic [n-1:0] r_mem [LANE_DEPTH];
    logic         r_wptr;
    logic         r_rptr;
    logic         r_valid;
    logic [n-1:0] r_dout;
    lane_state_t  r_state;

    logic         w_push;
    logic         w_pop;
    occ_t         w_cnt;
    occ_t         w_cnt_next;
    lane_state_t  w_state_next;
    logic         w_rptr_next;
    logic [n-1:0] w_mem_next [LANE_DEPTH];

    always_comb begin
        w_push       = i_push & (r_state != FULL);
        w_pop        = i_ready & (r_state != EMPTY);
        w_cnt        = occ_t'(r_state);
        w_cnt_next   = w_cnt + occ_t'(w_push) - occ_t'(w_pop);
        w_state_next = lane_state_t'(w_cnt_next);
        w_rptr_next  = r_rptr ^ w_pop;
        w_mem_next   = r_mem;
        if (w_push) begin
            w_mem_next[r_wptr] = i_data;
        end
    end

    // The head register looks ahead at the post-update storage, so a beat
    // written this edge into the slot the read pointer lands on shows next cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < LANE_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            r_valid <= 1'b0;
            r_dout  <= '0;
            r_state <= EMPTY;
        end else begin
            r_mem   <= w_mem_next;
            r_wptr  <= r_wptr ^ w_push;
            r_rptr  <= w_rptr_next;
            r_valid <= (w_state_next != EMPTY);
            r_dout  <= w_mem_next[w_rptr_next];
            r_state <= w_state_next;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_dout;
    assign o_state = r_state;
endmodule

// File: rtl/demux_1t2_buf.sv
// Registered 1-to-2 stream demultiplexer: SEL steers each accepted beat into
// one of two independent 2-entry lanes.
module demux_1t2_buf
    import demux_pkg::*;
#(
    parameter int n = 32
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic         IN_VALID,
    output logic         IN_READY,
    input  logic         SEL,
    input  logic [n-1:0] D_IN,
    output logic         OUT0_VALID,
    input  logic         OUT0_READY,
    output logic [n-1:0] D_OUT0,
    output logic         OUT1_VALID,
    input  logic         OUT1_READY,
    output logic [n-1:0] D_OUT1
);
    // IN_READY depends only on SEL and the selected lane's occupancy, never on
    // the consumers' READY; IN_VALID gates the push so an X on SEL while idle is harmless.

    lane_state_t w_state0;
    lane_state_t w_state1;
    logic        w_in_ready;
    logic        w_push0;
    logic        w_push1;

    always_comb begin
        w_in_ready = RST_N & (SEL ? (w_state1 != FULL) : (w_state0 != FULL));
        w_push0    = IN_VALID & w_in_ready & ~SEL;
        w_push1    = IN_VALID & w_in_ready & SEL;
    end

    assign IN_READY = w_in_ready;

    lane_fifo2 #(.n(n)) u_lane0 (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_push  (w_push0),
        .i_data  (D_IN),
        .i_ready (OUT0_READY),
        .o_valid (OUT0_VALID),
        .o_data  (D_OUT0),
        .o_state (w_state0)
    );

    lane_fifo2 #(.n(n)) u_lane1 (
        .i_clk   (CLK),
        .i_rst_n (RST_N),
        .i_push  (w_push1),
        .i_data  (D_IN),
        .i_ready (OUT1_READY),
        .o_valid (OUT1_VALID),
        .o_data  (D_OUT1),
        .o_state (w_state1)
    );
endmodule

// File: tb/tb_demux_1t2_buf.sv
// Bench for demux_1t2_buf: directed steps followed by random traffic, checked
// against two bounded queues modelling the lanes.
module tb_demux_1t2_buf;
    logic        CLK;
    logic        RST_N;
    logic        IN_VALID;
    logic        IN_READY;
    logic        SEL;
    logic [31:0] D_IN;
    logic        OUT0_VALID;
    logic        OUT0_READY;
    logic [31:0] D_OUT0;
    logic        OUT1_VALID;
    logic        OUT1_READY;
    logic [31:0] D_OUT1;

    int n_assert = 0;
    int n_fail   = 0;

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic [31:0] log0[$];
    logic [31:0] log1[$];
    bit          logging = 0;

    demux_1t2_buf #(.n(32)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .IN_VALID   (IN_VALID),
        .IN_READY   (IN_READY),
        .SEL        (SEL),
        .D_IN       (D_IN),
        .OUT0_VALID (OUT0_VALID),
        .OUT0_READY (OUT0_READY),
        .D_OUT0     (D_OUT0),
        .OUT1_VALID (OUT1_VALID),
        .OUT1_READY (OUT1_READY),
        .D_OUT1     (D_OUT1)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int lane_size(input logic sel);
        return sel ? exp_q1.size() : exp_q0.size();
    endfunction

    task automatic drive(input logic v, input logic s, input logic [31:0] d,
                         input logic r0, input logic r1);
        IN_VALID   = v;
        SEL        = s;
        D_IN       = d;
        OUT0_READY = r0;
        OUT1_READY = r1;
        #1;
    endtask

    task automatic check_model();
        chk("in_ready", {31'd0, IN_READY}, {31'd0, RST_N && (lane_size(SEL) < 2)});
        chk("out0_valid", {31'd0, OUT0_VALID}, {31'd0, exp_q0.size() != 0});
        chk("out1_valid", {31'd0, OUT1_VALID}, {31'd0, exp_q1.size() != 0});
        if (exp_q0.size() != 0) chk("d_out0", D_OUT0, exp_q0[0]);
        if (exp_q1.size() != 0) chk("d_out1", D_OUT1, exp_q1[0]);
        if (logging && OUT0_VALID && OUT0_READY) log0.push_back(D_OUT0);
        if (logging && OUT1_VALID && OUT1_READY) log1.push_back(D_OUT1);
    endtask

    // Inputs are stable from drive() until after the edge; model is updated
    // from the pre-edge occupancy, so a full lane refuses even while popping.
    task automatic cycle();
        bit acc;
        bit pop0;
        bit pop1;
        #3;
        check_model();
        @(posedge CLK);
        if (!RST_N) begin
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            acc  = IN_VALID && (lane_size(SEL) < 2);
            pop0 = OUT0_READY && (exp_q0.size() != 0);
            pop1 = OUT1_READY && (exp_q1.size() != 0);
            if (pop0) void'(exp_q0.pop_front());
            if (pop1) void'(exp_q1.pop_front());
            if (acc && !SEL) exp_q0.push_back(D_IN);
            if (acc && SEL)  exp_q1.push_back(D_IN);
        end
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, {31'd0, IN_READY}, 32'd0);
        chk({tag, "_out0_valid"}, {31'd0, OUT0_VALID}, 32'd0);
        chk({tag, "_out1_valid"}, {31'd0, OUT1_VALID}, 32'd0);
        chk({tag, "_d_out0"}, D_OUT0, 32'd0);
        chk({tag, "_d_out1"}, D_OUT1, 32'd0);
    endtask

    initial begin
        RST_N = 1'b0;
        IN_VALID = 1'b0; SEL = 1'b0; D_IN = '0; OUT0_READY = 1'b0; OUT1_READY = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        chk_all_zero("reset");
        RST_N = 1'b1;
        #1;
        chk("post_rst_d_out0", D_OUT0, 32'd0);
        chk("post_rst_out0_valid", {31'd0, OUT0_VALID}, 32'd0);

        // First beat to lane 0, visible one cycle later.
        drive(1, 0, 32'hA5A5_0001, 0, 0); cycle();
        drive(0, 0, 32'h0, 0, 0);
        chk("first_out0_valid", {31'd0, OUT0_VALID}, 32'd1);
        chk("first_d_out0", D_OUT0, 32'hA5A5_0001);
        chk("first_out1_valid", {31'd0, OUT1_VALID}, 32'd0);
        cycle();
        drive(0, 0, 32'h0, 1, 0); cycle();

        // Fill lane 1 with its consumer stalled; lane 0 still accepts.
        drive(1, 1, 32'h11, 1, 0); cycle();
        drive(1, 1, 32'h22, 1, 0); cycle();
        drive(1, 1, 32'h99, 1, 0);
        chk("full_lane1_ready", {31'd0, IN_READY}, 32'd0);
        cycle();
        drive(1, 0, 32'h33, 1, 0);
        chk("lane0_ready_while_lane1_full", {31'd0, IN_READY}, 32'd1);
        cycle();
        drive(0, 1, 32'h0, 1, 0);
        chk("lane0_d_out0_33", D_OUT0, 32'h33);
        chk("lane1_stall_hold", D_OUT1, 32'h11);
        cycle();

        // Full lane popping and pushed in the same cycle: push refused.
        drive(1, 1, 32'h44, 1, 1);
        chk("full_pop_push_ready", {31'd0, IN_READY}, 32'd0);
        cycle();
        drive(1, 1, 32'h44, 1, 1);
        chk("after_pop_d_out1", D_OUT1, 32'h22);
        chk("after_pop_ready", {31'd0, IN_READY}, 32'd1);
        cycle();
        drive(0, 1, 32'h0, 1, 1);
        chk("drain_d_out1_44", D_OUT1, 32'h44);
        cycle();
        drive(0, 0, 32'h0, 1, 1); cycle();

        // Alternating stream at full rate.
        logging = 1;
        for (int i = 0; i < 8; i++) begin
            drive(1, i[0], i, 1, 1);
            chk("stream_ready", {31'd0, IN_READY}, 32'd1);
            cycle();
        end
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 32'h0, 1, 1); cycle();
        end
        logging = 0;
        chk("stream_lane0_count", log0.size(), 32'd4);
        chk("stream_lane1_count", log1.size(), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < log0.size()) chk("stream_lane0_data", log0[i], 2 * i);
            if (i < log1.size()) chk("stream_lane1_data", log1[i], 2 * i + 1);
        end

        // Simultaneous push and pop from HALF.
        drive(1, 0, 32'h55, 0, 0); cycle();
        drive(1, 0, 32'h66, 1, 0); cycle();
        drive(0, 0, 32'h0, 0, 0);
        chk("half_pushpop_valid", {31'd0, OUT0_VALID}, 32'd1);
        chk("half_pushpop_d_out0", D_OUT0, 32'h66);
        cycle();
        drive(1, 0, 32'h67, 0, 0);
        chk("half_pushpop_cnt1", {31'd0, IN_READY}, 32'd1);
        cycle();
        drive(0, 0, 32'h0, 1, 0); cycle();
        drive(0, 0, 32'h0, 1, 0); cycle();

        // Asynchronous reset with both lanes full.
        drive(1, 0, 32'hC0, 0, 0); cycle();
        drive(1, 1, 32'hC1, 0, 0); cycle();
        drive(1, 0, 32'hC2, 0, 0); cycle();
        drive(1, 1, 32'hC3, 0, 0); cycle();
        drive(0, 0, 32'h0, 0, 0);
        RST_N = 1'b0;
        #1;
        chk_all_zero("async_rst");
        exp_q0.delete();
        exp_q1.delete();
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        drive(1, 1, 32'h77, 0, 0); cycle();
        drive(0, 0, 32'h0, 0, 0);
        chk("post_rst_out1_valid", {31'd0, OUT1_VALID}, 32'd1);
        chk("post_rst_d_out1", D_OUT1, 32'h77);
        chk("post_rst_out0_empty", {31'd0, OUT0_VALID}, 32'd0);
        cycle();
        drive(0, 0, 32'h0, 0, 1); cycle();
        drive(0, 0, 32'h0, 0, 0);
        chk("no_stale_out1", {31'd0, OUT1_VALID}, 32'd0);
        cycle();

        // Random traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
